// File: rtl/lsu_access_pkg.sv
// lsu_access_pkg: shared widths, access-size masks and FSM encoding for the LSU access stage.
package lsu_access_pkg;
    localparam int XLEN = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam logic [3:0] LS_B = 4'b0001;
    localparam logic [3:0] LS_H = 4'b0011;
    localparam logic [3:0] LS_W = 4'b1111;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} lsu_state_e;
endpackage

// File: rtl/lsu_access_if.sv
// lsu_access_if: data-bus request/response channel between the LSU (master) and memory (slave).
interface lsu_access_if #(parameter int ADDR_W = 32);
    logic              req;
    logic              gnt;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              rvalid;
    logic [31:0]       rdata;
    modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_access_be_gen.sv
// lsu_be_gen: byte enables and lane-replicated store data from size mask and address low bits.
// With LSU_MISALIGN_TRAP_EN it also flags misaligned half/word accesses.
module lsu_be_gen
    import lsu_access_pkg::*;
(
    input  logic [3:0]  mask,
    input  logic [1:0]  addr_low,
    input  logic [31:0] data,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [3:0]  be,
    output logic [31:0] wdata
);
    // shifting in a 4-bit context drops lanes past the word, giving the truncated enables
    assign be = mask << addr_low;
    assign wdata = mask == LS_B ? {4{data[7:0]}} : mask == LS_H ? {2{data[15:0]}} : data;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = mask == LS_H & addr_low[0] | mask == LS_W & addr_low != 2'b00;
`endif
endmodule

// File: rtl/lsu_access.sv
// lsu_access: EX->MEM load/store stage; issues one data-bus access at a time and stalls EX meanwhile.
// Optional LSU_MISALIGN_TRAP_EN retires misaligned half/word accesses without a bus request.
module lsu_access
    import lsu_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RESP_TIMEOUT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [XLEN-1:0]          ex_pc,
    input  logic [XLEN-1:0]          ex_inst,
    input  logic                     ex_is_load,
    input  logic                     ex_is_store,
    input  logic [4:0]               ex_ls_mask,
    input  logic [XLEN-1:0]          ex_alu_res,
    input  logic [XLEN-1:0]          ex_store_data,
    input  logic                     ex_req_rf,
    input  logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr,
    lsu_access_if.master             dbus,
    output logic                     mem_valid,
    output logic [XLEN-1:0]          mem_pc,
    output logic [XLEN-1:0]          mem_inst,
    output logic                     mem_is_load,
    output logic [XLEN-1:0]          mem_load_data,
    output logic [1:0]               mem_ls_addr_2low,
    output logic [4:0]               mem_l_mask,
    output logic                     mem_req_rf,
    output logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
    output logic [XLEN-1:0]          mem_alu_res,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                     mem_misalign,
`endif
    output logic                     mem_bus_err
);
    lsu_state_e state, state_n;
    logic [XLEN-1:0] p_pc, p_inst, p_alu;
    logic [4:0] p_mask;
    logic p_load, p_req_rf, d_we, mis, acc, mem_op, granted, rdone, tout, ret, from_ex;
    logic [RF_ADDR_WIDTH-1:0] p_waddr;
    logic [3:0] be, d_be;
    logic [31:0] wdata, d_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
    lsu_be_gen u_be (.mask(ex_ls_mask[3:0]), .addr_low(ex_alu_res[1:0]), .data(ex_store_data), .misalign(mis), .be(be), .wdata(wdata));
`else
    lsu_be_gen u_be (.mask(ex_ls_mask[3:0]), .addr_low(ex_alu_res[1:0]), .data(ex_store_data), .be(be), .wdata(wdata));
    assign mis = 1'b0;
`endif
    assign ex_ready = state == IDLE;
    assign from_ex = state == IDLE;
    assign acc = ex_valid & ex_ready;
    assign mem_op = (ex_is_load | ex_is_store) & !mis;
    assign granted = state == REQ & dbus.gnt;
    assign rdone = state == RESP & dbus.rvalid;
    assign dbus.req = state == REQ;
    assign dbus.addr = {p_alu[ADDR_W-1:2], 2'b00};
    assign dbus.be = d_be;
    assign dbus.wdata = d_wdata;
    assign dbus.we = d_we;
    generate
        if (RESP_TIMEOUT > 0) begin : g_to
            localparam int CW = RESP_TIMEOUT > 1 ? $clog2(RESP_TIMEOUT) : 1;
            logic [CW-1:0] cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt <= '0;
                else cnt <= state == RESP ? cnt + 1'b1 : '0;
            end
            assign tout = state == RESP & !dbus.rvalid & cnt == CW'(RESP_TIMEOUT - 1);
        end else begin : g_nto
            assign tout = 1'b0;
        end
    endgenerate
    always_comb begin
        state_n = acc & mem_op ? REQ : granted ? (p_load ? RESP : IDLE) : rdone | tout ? IDLE : state;
        ret = acc & !mem_op | granted & !p_load | rdone | tout;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            {p_pc, p_inst, p_alu, p_mask, p_load, p_req_rf, p_waddr} <= '0;
            {d_be, d_wdata, d_we} <= '0;
        end else begin
            state <= state_n;
            if (acc & mem_op) begin
                {p_pc, p_inst, p_alu, p_mask} <= {ex_pc, ex_inst, ex_alu_res, ex_ls_mask};
                {p_load, p_req_rf, p_waddr} <= {ex_is_load, ex_req_rf, ex_rf_waddr};
                {d_be, d_wdata, d_we} <= {be, wdata, ex_is_store & !ex_is_load};
            end
        end
    end
    // retirement source: EX directly from IDLE, otherwise the latched access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {mem_valid, mem_bus_err, mem_pc, mem_inst, mem_is_load, mem_load_data} <= '0;
            {mem_ls_addr_2low, mem_l_mask, mem_req_rf, mem_rf_waddr, mem_alu_res} <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mem_misalign <= 1'b0;
`endif
        end else begin
            mem_valid <= ret;
            mem_bus_err <= tout;
`ifdef LSU_MISALIGN_TRAP_EN
            mem_misalign <= ret & from_ex & mis;
`endif
            if (ret) begin
                mem_pc <= from_ex ? ex_pc : p_pc;
                mem_inst <= from_ex ? ex_inst : p_inst;
                mem_alu_res <= from_ex ? ex_alu_res : p_alu;
                mem_ls_addr_2low <= from_ex ? ex_alu_res[1:0] : p_alu[1:0];
                mem_rf_waddr <= from_ex ? ex_rf_waddr : p_waddr;
                mem_is_load <= !from_ex & p_load;
                mem_l_mask <= !from_ex & p_load ? p_mask : '0;
                mem_req_rf <= from_ex ? ex_req_rf & !mis : p_load & p_req_rf & !tout;
            end
            if (rdone) mem_load_data <= dbus.rdata;
        end
    end
endmodule

// File: doc/lsu_access.md
Name: lsu_access

Overview:
- Load/store access stage between EX and the MEM stage.
- Accepts one EX-stage instruction per cycle and issues data-bus requests for loads and stores. It stalls EX while an access is outstanding.
- Registers everything the MEM stage consumes: raw load word, address low bits, load mask, rd info and ALU result.
- Sign/zero extension of load data stays in the MEM stage. This block only delivers the raw aligned 32-bit word.

Parameters:
- ADDR_W, 32, data-bus address width; must equal `XLEN.
- RESP_TIMEOUT, 0, cycles to wait for dbus_rvalid before flagging mem_bus_err; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX instruction valid.
- ex_ready  out  1  block accepts EX instruction this cycle.
- ex_pc  in  `XLEN  instruction PC.
- ex_inst  in  `XLEN  instruction word.
- ex_is_load  in  1  load instruction.
- ex_is_store  in  1  store instruction.
- ex_ls_mask  in  5  bit4 = signed; [3:0] = size (0001 B, 0011 H, 1111 W).
- ex_alu_res  in  `XLEN  effective address (ld/st) or ALU result.
- ex_store_data  in  `XLEN  rs2 value.
- ex_req_rf  in  1  writes rd.
- ex_rf_waddr  in  `RF_ADDR_WIDTH  rd.
- dbus_req  out  1  request valid.
- dbus_gnt  in  1  request accepted.
- dbus_we  out  1  write.
- dbus_addr  out  ADDR_W  word-aligned address.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  write data.
- dbus_rvalid  in  1  read data valid.
- dbus_rdata  in  32  read data.
- mem_valid  out  1  MEM stage instruction valid.
- mem_pc, mem_inst  out  `XLEN  passthrough.
- mem_is_load  out  1.
- mem_load_data  out  `XLEN  raw bus word.
- mem_ls_addr_2low  out  2  ex_alu_res[1:0].
- mem_l_mask  out  5  ex_ls_mask for loads, else 0.
- mem_req_rf  out  1.
- mem_rf_waddr  out  `RF_ADDR_WIDTH.
- mem_alu_res  out  `XLEN.
- mem_bus_err  out  1  response timeout.

Behaviour:
- Reset: state IDLE. All mem_* outputs, dbus_req, dbus_we, dbus_addr, dbus_be and dbus_wdata are 0. ex_ready = 1.
- FSM states: IDLE, REQ, RESP.
- ex_ready = (state == IDLE).
- IDLE, accept (ex_valid & ex_ready):
  - Non-memory instruction: MEM registers load next edge, mem_valid = 1. Latency 1 cycle.
  - Load/store: latch the request into internal registers and go to REQ; mem_valid = 0 next cycle.
- IDLE with no accept: mem_valid = 0.
- REQ:
  - dbus_req = 1 with all dbus fields constant until dbus_gnt is seen at a clock edge.
  - On gnt with store: go to IDLE, mem_valid = 1 next cycle, mem_req_rf = 0.
  - On gnt with load: go to RESP, dbus_req = 0.
- RESP:
  - On dbus_rvalid: mem_load_data <= dbus_rdata, mem_valid = 1, go to IDLE.
  - rvalid is ignored outside RESP.
- Minimum latency: store 2 cycles, load 3 cycles, EX accept to mem_valid.
- dbus_addr = {addr[31:2], 2'b00}.
- dbus_be = (ex_ls_mask[3:0] << addr[1:0]) & 4'hF.
- dbus_wdata: byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
- mem_valid is a one-cycle pulse per retired instruction. There is no downstream backpressure.
- mem_* registers other than mem_valid hold their value when no instruction retires.
- Malformed instruction with ex_is_load & ex_is_store both set: treated as a load.
- Timeout (RESP_TIMEOUT > 0): the counter counts RESP cycles. On reaching RESP_TIMEOUT:
  - mem_valid = 1, mem_bus_err = 1, mem_req_rf = 0, go to IDLE.
  - A later stale rvalid is dropped.
- mem_bus_err pulses together with mem_valid and is 0 otherwise.
- Reset asserted mid-access: immediate return to IDLE. The bus transaction is abandoned; the bus slave shares rst_n.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port mem_misalign (1 bit).
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no bus request.
  - It retires after 1 cycle as a non-memory instruction with mem_misalign = 1 and mem_req_rf = 0.
- Undefined: no port. Misaligned accesses proceed with truncated dbus_be, e.g. word at offset 2 gives be = 4'b1100.

Decomposition:
- defines.v receives the shared constants:
  - LSU state encodings (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2).
  - Size masks: `LS_B = 4'b0001, `LS_H = 4'b0011, `LS_W = 4'b1111.
- One combinational sub-module, lsu_be_gen: maps mask, addr[1:0] and store data to dbus_be, dbus_wdata and the misalign flag.

Test Plan:
- ALU op, ex_alu_res = 0x1234 -> next cycle mem_valid = 1, mem_alu_res = 0x1234, no dbus_req.
- SB, addr 0x103, data 0xAB, gnt same cycle as req -> dbus_addr 0x100, be 1000, wdata 0xABABABAB; mem_valid 2 cycles after accept, mem_req_rf = 0.
- LH, addr 0x202, ex_ls_mask 10011, gnt delayed 3 cycles, rvalid 2 cycles later with rdata 0x8001_7F00:
  - ex_ready low throughout the access.
  - mem_load_data = 0x80017F00, mem_ls_addr_2low = 2, mem_l_mask = 10011.
- Back-to-back LW then ALU op -> ALU op held (ex_ready = 0) until the load retires; mem_valid pulses in program order.
- RESP_TIMEOUT = 4, rvalid never arrives -> mem_bus_err = 1 on the 4th RESP cycle, ex_ready returns to 1.
- LSU_MISALIGN_TRAP_EN, LW at 0x101 -> no dbus_req, mem_misalign = 1 one cycle after accept.
